// File: rtl/shift_merge_pkg.sv
// shift_merge_pkg: op encodings and width-generic mask/rotate helpers
// shared by the shift/merge pipeline. Helpers work on 64-bit containers.
package shift_merge_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        OP_MERGE   = 2'b00,
        OP_EXTRACT = 2'b01,
        OP_ROTATE  = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    // Low-order mask of len ones; len==0 (or len>=width) gives the
    // full width-bit mask without ever forming 1<<width.
    function automatic logic [MAXW-1:0] field_mask(
        input logic [6:0] len,
        input int         width
    );
        logic [MAXW-1:0] full;
        full = {MAXW{1'b1}} >> (MAXW - width);
        if (len == 7'd0 || int'(len) >= width)
            return full;
        return (64'd1 << len) - 64'd1;
    endfunction

    // Right-rotate within the low width bits of value.
    function automatic logic [MAXW-1:0] rotr(
        input logic [MAXW-1:0] value,
        input logic [5:0]      amount,
        input int              width
    );
        logic [MAXW-1:0] full;
        logic [MAXW-1:0] v;
        full = {MAXW{1'b1}} >> (MAXW - width);
        v    = value & full;
        return ((v >> amount) | (v << (width - int'(amount)))) & full;
    endfunction

endpackage

// File: rtl/shift_merge_pipe_if.sv
// shift_merge_pipe_if: request/result handshake bundle of shift_merge_pipe.
// slave = datapath side, master = requester/consumer side.
// Optional sext field exists only with SHIFT_MERGE_SIGN_EXT_EN.
interface shift_merge_pipe_if #(
    parameter int W = 8
);
    localparam int LW = $clog2(W);

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  shift_in;
    logic [W-1:0]  merge_in;
    logic [LW-1:0] src_pos;
    logic [LW-1:0] len;
    logic [LW-1:0] dst_lsb;
`ifdef SHIFT_MERGE_SIGN_EXT_EN
    logic          sext;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    modport slave (
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        input  sext,
`endif
        input  in_valid, op, shift_in, merge_in,
        input  src_pos, len, dst_lsb, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        output sext,
`endif
        output in_valid, op, shift_in, merge_in,
        output src_pos, len, dst_lsb, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_merge_pipe_field_extract.sv
// field_extract: combinational stage-1 rotate and field mask.
// Ports: shift_in/src_pos/len in; rot, field, len_eff (1..W) out.
module field_extract
    import shift_merge_pkg::*;
#(
    parameter int W = 8,
    localparam int LW = $clog2(W)
) (
    input  logic [W-1:0]  shift_in,
    input  logic [LW-1:0] src_pos,
    input  logic [LW-1:0] len,
    output logic [W-1:0]  rot,
    output logic [W-1:0]  field,
    output logic [LW:0]   len_eff
);

    always_comb begin
        rot     = W'(rotr(MAXW'(shift_in), 6'(src_pos), W));
        field   = rot & W'(field_mask(7'(len), W));
        len_eff = (len == '0) ? (LW+1)'(W) : {1'b0, len};
    end

endmodule

// File: rtl/shift_merge_pipe.sv
// shift_merge_pipe: two-stage rotate/mask/merge datapath, valid/ready
// on both sides. Ports: clk, rst_n (sync, active-low), bus (slave).
// Option: SHIFT_MERGE_SIGN_EXT_EN adds sign-extending EXTRACT (bus.sext).
module shift_merge_pipe
    import shift_merge_pkg::*;
#(
    parameter int W = 8
) (
    input logic             clk,
    input logic             rst_n,
    shift_merge_pipe_if.slave bus
);

    localparam int LW = $clog2(W);

    typedef struct packed {
        logic [W-1:0]  field;
        logic [W-1:0]  rot;
        op_e           op;
        logic [W-1:0]  merge;
        logic [LW-1:0] dst_lsb;
        logic [LW:0]   len_eff;
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        logic          sext;
`endif
    } s1_t;

    s1_t          s1_d;
    s1_t          s1_q;
    logic         s1_v;
    logic         s2_v;
    logic [W-1:0] s2_d;
    logic [W-1:0] s2_q;
    logic         s2_en;
    logic [W-1:0] fx_rot;
    logic [W-1:0] fx_field;
    logic [LW:0]  fx_len;
    logic [W-1:0] lmask;
    logic [W-1:0] mmask;
    logic [W-1:0] fext;

    field_extract #(.W(W)) u_fx (
        .shift_in (bus.shift_in),
        .src_pos  (bus.src_pos),
        .len      (bus.len),
        .rot      (fx_rot),
        .field    (fx_field),
        .len_eff  (fx_len)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.field   = fx_field;
        s1_d.rot     = fx_rot;
        s1_d.op      = op_e'(bus.op);
        s1_d.merge   = bus.merge_in;
        s1_d.dst_lsb = bus.dst_lsb;
        s1_d.len_eff = fx_len;
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        s1_d.sext    = bus.sext;
`endif
    end

    // Bits of the mask/field pushed past W-1 are truncated, never wrapped.
    always_comb begin
        lmask = W'(field_mask(7'(s1_q.len_eff), W));
        mmask = W'(MAXW'(lmask) << s1_q.dst_lsb);
        fext  = s1_q.field;
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        // For L==W ~lmask is zero, so the field is unchanged.
        if (s1_q.sext && s1_q.field[s1_q.len_eff - 1'b1])
            fext = s1_q.field | ~lmask;
`endif
        unique case (1'b1)
            (s1_q.op == OP_EXTRACT): s2_d = fext;
            (s1_q.op == OP_ROTATE):  s2_d = s1_q.rot;
            default:
                s2_d = (s1_q.merge & ~mmask)
                     | (W'(MAXW'(s1_q.field) << s1_q.dst_lsb) & mmask);
        endcase
    end

    assign s2_en         = !s2_v || bus.out_ready;
    assign bus.in_ready  = rst_n && (!s1_v || s2_en);
    assign bus.out_valid = s2_v;
    assign bus.out_data  = s2_q;
    assign bus.busy      = s1_v | s2_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v)
                    s2_q <= s2_d;
            end
            if (bus.in_ready) begin
                s1_v <= bus.in_valid;
                if (bus.in_valid)
                    s1_q <= s1_d;
            end
        end
    end

endmodule

// File: tb/tb_shift_merge_pipe.sv
// tb_shift_merge_pipe: directed checks of shift_merge_pipe at W=8.
// Covers reset, each op, len=0 edge, streaming, backpressure, mid-op reset.
module tb_shift_merge_pipe;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_merge_pipe_if #(.W(8)) bus ();

    shift_merge_pipe #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHIFT_MERGE_SIGN_EXT_EN
    localparam logic [7:0] EXT_EXP = 8'hFB;
`else
    localparam logic [7:0] EXT_EXP = 8'h0B;
`endif

    logic [1:0] op_v [4] = '{2'd0, 2'd1, 2'd0, 2'd2};
    logic [7:0] sh_v [4] = '{8'hA5, 8'hB4, 8'h81, 8'h01};
    logic [7:0] mg_v [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    logic [2:0] ps_v [4] = '{3'd0, 3'd4, 3'd0, 3'd1};
    logic [2:0] ln_v [4] = '{3'd3, 3'd4, 3'd0, 3'd0};
    logic [2:0] ds_v [4] = '{3'd2, 3'd0, 3'd3, 3'd0};
    logic [7:0] ex_v [4] = '{8'hF7, 8'h0B, 8'h08, 8'h80};

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [7:0] s,
                         input logic [7:0] m, input logic [2:0] p,
                         input logic [2:0] l, input logic [2:0] d);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.shift_in = s;
        bus.merge_in = m;
        bus.src_pos  = p;
        bus.len      = l;
        bus.dst_lsb  = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input string tag, input logic [1:0] o,
                            input logic [7:0] s, input logic [7:0] m,
                            input logic [2:0] p, input logic [2:0] l,
                            input logic [2:0] d, input logic [7:0] exp);
        drive(o, s, m, p, l, d);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_pend"}, {7'd0, bus.out_valid}, 8'd0);
        step();
        chk({tag, "_valid"}, {7'd0, bus.out_valid}, 8'd1);
        chk({tag, "_data"}, bus.out_data, exp);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        bus.sext     = 1'b0;
`endif
        drive(2'd0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        bus.in_valid = 1'b0;

        step();
        step();
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {7'd0, bus.in_ready}, 8'd1);

        one_shot("merge", 2'd0, 8'hA5, 8'hFF, 3'd0, 3'd3, 3'd2, 8'hF7);
        one_shot("rsvd", 2'd3, 8'hA5, 8'hFF, 3'd0, 3'd3, 3'd2, 8'hF7);
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        bus.sext = 1'b1;
`endif
        one_shot("extract", 2'd1, 8'hB4, 8'h00, 3'd4, 3'd4, 3'd0, EXT_EXP);
`ifdef SHIFT_MERGE_SIGN_EXT_EN
        one_shot("sext_full", 2'd1, 8'h96, 8'h00, 3'd0, 3'd0, 3'd0,
                 8'h96);
        bus.sext = 1'b0;
`endif
        one_shot("extract_zf", 2'd1, 8'hB4, 8'h00, 3'd4, 3'd4, 3'd0,
                 8'h0B);
        one_shot("len0", 2'd0, 8'h81, 8'h00, 3'd0, 3'd0, 3'd3, 8'h08);
        one_shot("rotate", 2'd2, 8'h01, 8'h5A, 3'd1, 3'd3, 3'd5, 8'h80);
        step();
        chk("idle_busy", {7'd0, bus.busy}, 8'd0);

        // back-to-back stream
        for (int i = 0; i < 6; i++) begin
            if (i < 4)
                drive(op_v[i], sh_v[i], mg_v[i], ps_v[i], ln_v[i], ds_v[i]);
            else
                bus.in_valid = 1'b0;
            step();
            if (i >= 1 && i < 5) begin
                chk($sformatf("stream%0d_valid", i - 1),
                    {7'd0, bus.out_valid}, 8'd1);
                chk($sformatf("stream%0d_data", i - 1),
                    bus.out_data, ex_v[i - 1]);
                chk($sformatf("stream%0d_in_ready", i - 1),
                    {7'd0, bus.in_ready}, 8'd1);
            end
        end
        chk("stream_drain", {7'd0, bus.out_valid}, 8'd0);

        // backpressure
        bus.out_ready = 1'b0;
        drive(2'd0, 8'hA5, 8'hFF, 3'd0, 3'd3, 3'd2);
        step();
        chk("bp_ready1", {7'd0, bus.in_ready}, 8'd1);
        drive(2'd1, 8'hB4, 8'h00, 3'd4, 3'd4, 3'd0);
        step();
        drive(2'd2, 8'h01, 8'h00, 3'd1, 3'd0, 3'd0);
        chk("bp_full_ready", {7'd0, bus.in_ready}, 8'd0);
        chk("bp_valid", {7'd0, bus.out_valid}, 8'd1);
        chk("bp_data0", bus.out_data, 8'hF7);
        step();
        chk("bp_hold_data", bus.out_data, 8'hF7);
        chk("bp_hold_valid", {7'd0, bus.out_valid}, 8'd1);
        chk("bp_hold_ready", {7'd0, bus.in_ready}, 8'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_data1", bus.out_data, 8'h0B);
        step();
        chk("bp_data2", bus.out_data, 8'h80);
        chk("bp_valid2", {7'd0, bus.out_valid}, 8'd1);
        step();
        chk("bp_empty", {7'd0, bus.busy}, 8'd0);

        // reset with two entries in flight
        bus.out_ready = 1'b0;
        drive(2'd0, 8'hA5, 8'hFF, 3'd0, 3'd3, 3'd2);
        step();
        drive(2'd2, 8'h01, 8'h00, 3'd1, 3'd0, 3'd0);
        step();
        bus.in_valid = 1'b0;
        chk("mid_busy", {7'd0, bus.busy}, 8'd1);
        chk("mid_valid", {7'd0, bus.out_valid}, 8'd1);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("mrst_busy", {7'd0, bus.busy}, 8'd0);
        chk("mrst_data", bus.out_data, 8'h00);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("no_stale%0d", i), {7'd0, bus.out_valid}, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
